mem_wb_stage: RTL

Parametrised MEM/WB pipeline stage with a valid/ready handshake, a two-entry skid buffer, flush, and a resolved write-back path. It sits between the data-memory stage and the register file and replaces the plain per-cycle latch used so far. It adds three capabilities: back-pressure from write-back, squashing of in-flight instructions, and selection of the write-back data inside the stage.

---
 rtl/mem_wb_stage.sv | 94 +++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline stage with valid/ready handshake, two-entry skid buffer, flush and write-back select
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W = 5,
  parameter bit ZERO_REG_GUARD = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              hit_in,
  input  logic [DATA_W-1:0] read_data_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [REG_W-1:0]  write_reg_in,
  input  logic              reg_write_in,
  input  logic              mem_to_reg_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              hit_out,
  output logic [DATA_W-1:0] read_data_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [REG_W-1:0]  write_reg_out,
  output logic              reg_write_out,
  output logic              mem_to_reg_out,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_en,
  output logic [1:0]        occupancy
);
  typedef struct packed {
    logic              hit;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] alu_result;
    logic [REG_W-1:0]  write_reg;
    logic              reg_write;
    logic              mem_to_reg;
  } payload_t;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t   state, state_nxt;
  payload_t main_q, skid_q, in_pl, main_nxt;
  logic     load_main, load_skid, accept, drain;
  assign in_pl = '{hit: hit_in, read_data: read_data_in, alu_result: alu_result_in,
                   write_reg: write_reg_in, reg_write: reg_write_in, mem_to_reg: mem_to_reg_in};
  assign out_valid = state != EMPTY;
  assign in_ready = state != TWO && !flush && !reset;
  assign accept = in_valid && in_ready;
  assign drain = out_valid && out_ready;
  assign occupancy = state;
  assign hit_out = main_q.hit;
  assign read_data_out = main_q.read_data;
  assign alu_result_out = main_q.alu_result;
  assign write_reg_out = main_q.write_reg;
  assign reg_write_out = main_q.reg_write;
  assign mem_to_reg_out = main_q.mem_to_reg;
  assign wb_data = main_q.mem_to_reg ? main_q.read_data : main_q.alu_result;
  assign wb_en = drain && !reset && main_q.reg_write && (!ZERO_REG_GUARD || main_q.write_reg != '0);
  // next occupancy state and which slot loads; flush empties the stage without capturing input
  always_comb begin
    state_nxt = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    main_nxt = in_pl;
    if (flush) state_nxt = EMPTY;
    else
      case (state)
        EMPTY: begin
          state_nxt = accept ? ONE : EMPTY;
          load_main = accept;
        end
        ONE: begin
          state_nxt = accept ? (drain ? ONE : TWO) : (drain ? EMPTY : ONE);
          load_main = accept && drain;
          load_skid = accept && !drain;
        end
        default: begin
          state_nxt = drain ? ONE : TWO;
          load_main = drain;
          main_nxt = skid_q;
        end
      endcase
  end
  // state and payload registers; payloads change only on accept or skid-to-main shift
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state <= state_nxt;
      if (load_main) main_q <= main_nxt;
      if (load_skid) skid_q <= in_pl;
    end
  end
endmodule
